clock_reset_manager: RTL and testbench
======================================

# clock_reset_manager

Board-level clock and reset front end placed in each FPGA top between the raw board inputs (oscillator, reset push-button) and `Grande_Risco_5_SOC`. It divides the board clock into the SoC clock with a fixed 50% duty cycle and debounces and synchronizes the reset button. It holds the SoC in reset for a programmable stretch after a clean release, then deasserts reset aligned to a falling edge of the divided clock. The SoC therefore always leaves reset with a full half-period of margin and never sees a bouncing or metastable reset.

## Interface
- `DIV_RATIO`, 2: board-clock cycles per SoC clock period; even, ≥2.
- `DEBOUNCE_CYCLES`, 1000000: clk cycles the synchronized button level must stay unchanged before it is accepted; ≥1.
- `HOLD_CYCLES`, 16: clk cycles of accepted-released button required before the reset release sequence starts; ≥1.
- `clk`  in  1  board oscillator; every register is clocked on its rising edge.
- `rst_n`  in  1  global reset, asynchronous, active-low; forces every register to its reset value immediately.
- `btn_rst_n`  in  1  raw reset push-button, asynchronous to `clk`, active-low, may bounce.
- `clk_o`  out  1  divided SoC clock, registered.
- `clk_en`  out  1  one-`clk` pulse in the cycle whose closing edge raises `clk_o`.
- `soc_rst_n`  out  1  SoC reset, active-low, registered.
- `reset_active`  out  1  high whenever the block is not in RUN; intended for an LED.

## Operation
- Reset values (`rst_n`=0):
  - `clk_o`=0, `div_cnt`=0, `clk_en`=0.
  - `soc_rst_n`=0, `reset_active`=1.
  - Both synchronizer flops=0 and `btn_stable`=0, so the button path powers up in the "pressed" state.
  - `deb_cnt`=0, `hold_cnt`=0, state=HOLD.
- Divider: free-running, cleared only by `rst_n`; the button never affects it.
  - `div_cnt` counts 0..DIV_RATIO/2−1.
  - At DIV_RATIO/2−1, `div_cnt` returns to 0 and `clk_o` toggles.
  - `clk_en` = (`div_cnt`==DIV_RATIO/2−1) && !`clk_o`, decoded from registers, no latches.
  - A falling-edge event is a toggle edge while `clk_o`==1.
- Button synchronizer: a two-flop synchronizer on `btn_rst_n` produces `btn_sync`.
- Debounce:
  - While `btn_sync`≠`btn_stable`, `deb_cnt` increments.
  - When `deb_cnt`==DEBOUNCE_CYCLES−1 and the levels still differ, `btn_stable`<=`btn_sync` and `deb_cnt`<=0.
  - Whenever `btn_sync`==`btn_stable`, `deb_cnt`<=0.
  - `deb_cnt` is wide enough for DEBOUNCE_CYCLES−1 and never wraps.
- FSM:
  - HOLD: `btn_stable`=0 → `hold_cnt`<=0. Otherwise `hold_cnt` increments. At `hold_cnt`==HOLD_CYCLES−1 with `btn_stable`=1, go to ALIGN with `hold_cnt`<=0.
  - ALIGN: `btn_stable`=0 → back to HOLD. On the falling-edge event, `soc_rst_n`<=1 and go to RUN.
  - RUN: `btn_stable`=0 → `soc_rst_n`<=0 on that same edge (no clock alignment on assertion) and go to HOLD.
- `reset_active` = (state≠RUN), registered alongside the state.
- Simultaneous events:
  - `btn_stable` falling in the same cycle as the ALIGN falling-edge event: HOLD wins and `soc_rst_n` stays 0.
  - `rst_n` overrides everything, asynchronously, in any state.

## Timing
- Divider: `clk_o` period is exactly DIV_RATIO cycles with exactly DIV_RATIO/2 high. The first rising edge of `clk_o` comes DIV_RATIO/2 cycles after the first `clk` edge with `rst_n`=1.
- Release latency, counted from the first `clk` edge after `btn_rst_n` goes high and stays high: `soc_rst_n` rises between 2+DEBOUNCE_CYCLES+HOLD_CYCLES and 2+DEBOUNCE_CYCLES+HOLD_CYCLES+DIV_RATIO cycles. It always rises on the same edge that takes `clk_o` from 1 to 0.
- The same latency applies after `rst_n` deasserts with the button already released, because `btn_stable` starts at 0.
- Assertion latency: `soc_rst_n` falls between 2+DEBOUNCE_CYCLES and 3+DEBOUNCE_CYCLES cycles after a sustained press.
- Bounce tolerance: a button pulse shorter than DEBOUNCE_CYCLES synchronized cycles has no effect on `soc_rst_n`.
- Outputs are glitch-free: `clk_o`, `soc_rst_n` and `reset_active` come straight from flops.

## Test plan
All scenarios use DIV_RATIO=4, DEBOUNCE_CYCLES=8, HOLD_CYCLES=4 unless stated.
- Power-up:
  - Stimulus: `rst_n` low for 5 cycles, `btn_rst_n`=1.
  - Required: all outputs at reset values during reset. Afterwards `clk_o` is 0,0,1,1,… with `clk_en` high every 4th cycle. `soc_rst_n` rises once, within 14..18 cycles, on a `clk_o` 1→0 edge, and `reset_active` then falls.
- Glitch rejection:
  - Stimulus: in RUN, `btn_rst_n` low for 5 cycles.
  - Required: `soc_rst_n` and `reset_active` never change.
- Press/release:
  - Stimulus: `btn_rst_n` low for 30 cycles.
  - Required: `soc_rst_n` falls 10–11 cycles after the press and `clk_o` is never interrupted. After release, `soc_rst_n` rises within 14..18 cycles.
- Release bounce:
  - Stimulus: `btn_rst_n` toggles every 3 cycles for 30 cycles, then stays high.
  - Required: `soc_rst_n` rises only after the stable period, within 14..18 cycles of the last edge.
- Async reset mid-RUN:
  - Stimulus: pulse `rst_n` low between `clk` edges.
  - Required: `soc_rst_n`=0, `clk_o`=0 and `reset_active`=1 immediately, with no clock edge needed.
- DIV_RATIO=2:
  - Required: `clk_o` toggles every cycle, `clk_en` is high on alternate cycles, and release aligns to a `clk_o` falling edge.

Source files
------------

// File: rtl/clock_reset_manager_if.sv
// Board-side signal bundle of the clock/reset front end: raw button in,
// divided SoC clock and conditioned SoC reset out.
interface clock_reset_manager_if;
    logic btn_rst_n;
    logic clk_o;
    logic clk_en;
    logic soc_rst_n;
    logic reset_active;

    modport master (
        input  btn_rst_n,
        output clk_o,
        output clk_en,
        output soc_rst_n,
        output reset_active
    );

    modport slave (
        output btn_rst_n,
        input  clk_o,
        input  clk_en,
        input  soc_rst_n,
        input  reset_active
    );
endinterface

// File: rtl/clock_reset_manager.sv
// Divides the board clock into a 50% SoC clock and turns the bouncing reset
// button into a clean SoC reset that is released on a falling clk_o edge.
module clock_reset_manager #(
    parameter int DIV_RATIO       = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    clock_reset_manager_if.master        bus
);

    localparam int HALF   = DIV_RATIO / 2;
    localparam int DIV_W  = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(HALF - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    logic [DIV_W-1:0]  r_div_cnt;
    logic              r_clk_o;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_btn_stable;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    state_t            r_state;
    logic              r_soc_rst_n;
    logic              r_reset_active;

    logic              w_div_wrap;
    logic              w_fall;
    state_t            w_state_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_soc_nxt;

    assign w_div_wrap = (r_div_cnt == DIV_LAST);
    assign w_fall     = w_div_wrap && r_clk_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_clk_o   <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_clk_o   <= ~r_clk_o;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Button path powers up as "pressed" so the SoC always sees a full release sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_btn_stable <= 1'b0;
            r_deb_cnt    <= '0;
        end else begin
            r_sync1 <= bus.btn_rst_n;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_btn_stable) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == DEB_LAST) begin
                r_btn_stable <= r_sync2;
                r_deb_cnt    <= '0;
            end else begin
                r_deb_cnt <= r_deb_cnt + DEB_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_soc_nxt   = r_soc_rst_n;
        case (r_state)
            ST_HOLD: begin
                if (!r_btn_stable) begin
                    w_hold_nxt = '0;
                end else if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_ALIGN;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            ST_ALIGN: begin
                // A new press beats a coincident falling edge: reset stays asserted.
                if (!r_btn_stable) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_fall) begin
                    w_soc_nxt   = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!r_btn_stable) begin
                    w_soc_nxt   = 1'b0;
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_hold_nxt  = '0;
                w_soc_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_HOLD;
            r_hold_cnt     <= '0;
            r_soc_rst_n    <= 1'b0;
            r_reset_active <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_nxt;
            r_soc_rst_n    <= w_soc_nxt;
            r_reset_active <= (w_state_nxt != ST_RUN);
        end
    end

    assign bus.clk_o        = r_clk_o;
    // Gated by rst_n so a divide-by-2 build still shows 0 while held in reset.
    assign bus.clk_en       = w_div_wrap && !r_clk_o && rst_n;
    assign bus.soc_rst_n    = r_soc_rst_n;
    assign bus.reset_active = r_reset_active;

endmodule

// File: tb/tb_clock_reset_manager.sv
// Directed bench for clock_reset_manager: a divide-by-4 instance checked
// against a cycle table and corner sequences, plus a divide-by-2 instance.
module tb_clock_reset_manager;

    logic clk;
    logic rst_n;
    logic btn;
    int   checks;
    int   errors;
    int   cyc;

    clock_reset_manager_if bus1 ();
    clock_reset_manager_if bus2 ();

    assign bus1.btn_rst_n = btn;
    assign bus2.btn_rst_n = btn;

    clock_reset_manager #(
        .DIV_RATIO(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(4)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus1)
    );

    clock_reset_manager #(
        .DIV_RATIO(2), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(4)
    ) u_dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic clk_o;
        logic clk_en;
        logic soc;
        logic ra;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clk edge, then divider continuity checks for both instances.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("div4_clk_o", bus1.clk_o, 1'((cyc % 4) == 2 || (cyc % 4) == 3));
        chk("div4_clk_en", bus1.clk_en, 1'((cyc % 4) == 1));
        chk("div2_clk_o", bus2.clk_o, 1'((cyc % 2) == 1));
        chk("div2_clk_en", bus2.clk_en, 1'((cyc % 2) == 0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_clk_o", bus1.clk_o, 1'b0);
        chk("rst_clk_en", bus1.clk_en, 1'b0);
        chk("rst_soc", bus1.soc_rst_n, 1'b0);
        chk("rst_ra", bus1.reset_active, 1'b1);
        chk("rst2_clk_en", bus2.clk_en, 1'b0);
        chk("rst2_soc", bus2.soc_rst_n, 1'b0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic measure_release(input string name);
        int   k_rise;
        logic aligned;
        k_rise  = 0;
        aligned = 1'b0;
        btn = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            logic pc;
            pc = bus1.clk_o;
            step();
            if (bus1.soc_rst_n === 1'b1) begin
                k_rise  = k;
                aligned = (pc === 1'b1) && (bus1.clk_o === 1'b0);
                break;
            end
        end
        chk_rng(name, k_rise, 14, 18);
        chk({name, "_align"}, aligned, 1'b1);
        chk({name, "_ra"}, bus1.reset_active, 1'b0);
    endtask

    task automatic measure_press(input string name, input int len);
        int k_fall;
        k_fall = 0;
        btn = 1'b0;
        for (int k = 1; k <= len; k++) begin
            step();
            if (k_fall == 0 && bus1.soc_rst_n === 1'b0) k_fall = k;
        end
        chk_rng(name, k_fall, 10, 11);
        chk({name, "_ra"}, bus1.reset_active, 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        btn    = 1'b1;
        rst_n  = 1'b0;

        //              btn   clk_o clk_en soc  ra
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Power-up
        do_reset();
        for (int i = 0; i < 20; i++) begin
            btn = tbl[i].btn;
            step();
            chk($sformatf("pwr_clk_o[%0d]", i), bus1.clk_o, tbl[i].clk_o);
            chk($sformatf("pwr_clk_en[%0d]", i), bus1.clk_en, tbl[i].clk_en);
            chk($sformatf("pwr_soc[%0d]", i), bus1.soc_rst_n, tbl[i].soc);
            chk($sformatf("pwr_ra[%0d]", i), bus1.reset_active, tbl[i].ra);
        end

        // Glitch rejection
        btn = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (k == 5) btn = 1'b1;
            step();
            chk("glitch_soc", bus1.soc_rst_n, 1'b1);
            chk("glitch_ra", bus1.reset_active, 1'b0);
        end

        // Press / release
        measure_press("press_lat", 30);
        measure_release("release_lat");

        // Release bounce
        measure_press("bounce_press_lat", 20);
        for (int i = 0; i < 10; i++) begin
            btn = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (3) begin
                step();
                chk("bounce_soc", bus1.soc_rst_n, 1'b0);
            end
        end
        measure_release("bounce_release_lat");

        // Async reset mid-RUN, applied between clk edges while clk_o is high
        for (int k = 0; k < 4 && bus1.clk_o !== 1'b1; k++) step();
        chk("async_pre_clk_o", bus1.clk_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_soc", bus1.soc_rst_n, 1'b0);
        chk("async_clk_o", bus1.clk_o, 1'b0);
        chk("async_ra", bus1.reset_active, 1'b1);
        chk("async_clk_en", bus1.clk_en, 1'b0);
        chk("async2_soc", bus2.soc_rst_n, 1'b0);
        chk("async2_clk_o", bus2.clk_o, 1'b0);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        // Second power-up: divide-by-2 release alignment
        begin
            int   k_rise2;
            logic aligned2;
            k_rise2  = 0;
            aligned2 = 1'b0;
            for (int k = 1; k <= 30; k++) begin
                logic pc2;
                pc2 = bus2.clk_o;
                step();
                if (k_rise2 == 0 && bus2.soc_rst_n === 1'b1) begin
                    k_rise2  = k;
                    aligned2 = (pc2 === 1'b1) && (bus2.clk_o === 1'b0);
                end
            end
            chk_rng("div2_release_lat", k_rise2, 14, 16);
            chk("div2_release_align", aligned2, 1'b1);
            chk("div2_ra", bus2.reset_active, 1'b0);
            chk("repower_soc", bus1.soc_rst_n, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
